// File: rtl/dmem_bridge.sv
// dmem_bridge: turns data-cache line misses into four single-word beats on an
// SRAM-style memory port with a ready handshake and a fixed 1-cycle read latency.
//
// Ports
//   clk, reset                 : rising-edge clock, asynchronous active-high reset
//   req, wr, daddr, dirty_data : line request from the cache (sampled only in IDLE)
//   data_i, valid              : refill word and its single-cycle qualifier
//   wr_done, rd_done           : single-cycle completion pulses
//   mem_cs, mem_we, mem_addr,
//   mem_wdata, mem_rdata,
//   mem_ready                  : memory beat port; a beat is accepted on mem_cs && mem_ready
//   err                        : sticky flag, set after TMO_CYC consecutive stalled cycles
//
// Optional build macro: DMEM_CWF_EN enables critical-word-first ordering for refills
// (start beat = daddr[3:2], wrapping). Write-backs always use beat order 0,1,2,3.
module dmem_bridge #(
  parameter int unsigned MEM_AW  = 18,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [19:0]       daddr,
  input  logic [127:0]      dirty_data,
  output logic [31:0]       data_i,
  output logic              valid,
  output logic              wr_done,
  output logic              rd_done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    WBEAT,
    RBEAT,
    RLAST,
    DONE
  } state_t;

  state_t       state, state_nxt;
  logic         capture;
  logic         accept;
  logic [15:0]  line_q;
  logic         wr_q;
  logic [127:0] wbuf_q;
  logic [1:0]   beat_q;
  logic [1:0]   start_q;
  logic [1:0]   word_sel;
  logic         armed_q;
  logic [7:0]   tmo_q;
  logic         err_q;
  logic         pend_q;
  logic [31:0]  data_q;
  logic         valid_q;
  logic         wr_done_q;
  logic         rd_done_q;
  logic         unused_daddr;

`ifdef DMEM_CWF_EN
  assign unused_daddr = ^daddr[1:0];
`else
  assign unused_daddr = ^daddr[3:0];
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and beat-port strobes
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (req && armed_q) begin
          capture   = 1'b1;
          state_nxt = wr ? WBEAT : RBEAT;
        end
      end
      WBEAT: begin
        mem_cs = 1'b1;
        mem_we = 1'b1;
        if (mem_ready && (beat_q == 2'd3)) state_nxt = DONE;
      end
      RBEAT: begin
        mem_cs = 1'b1;
        if (mem_ready && (beat_q == 2'd3)) state_nxt = RLAST;
      end
      RLAST:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = mem_cs && mem_ready;

  // Beat count is how many beats were accepted; the word index adds the start offset
  // so that critical-word-first simply rotates the order modulo 4.
  assign word_sel = beat_q + start_q;

  assign mem_addr = mem_cs ? MEM_AW'({line_q, word_sel}) : '0;

  always_comb begin
    mem_wdata = '0;
    if (mem_we) begin
      case (word_sel)
        2'd0:    mem_wdata = wbuf_q[31:0];
        2'd1:    mem_wdata = wbuf_q[63:32];
        2'd2:    mem_wdata = wbuf_q[95:64];
        default: mem_wdata = wbuf_q[127:96];
      endcase
    end
  end

  // Request capture and beat sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q  <= '0;
      wr_q    <= 1'b0;
      wbuf_q  <= '0;
      beat_q  <= '0;
      start_q <= '0;
    end else if (capture) begin
      line_q  <= daddr[19:4];
      wr_q    <= wr;
      wbuf_q  <= dirty_data;
      beat_q  <= '0;
`ifdef DMEM_CWF_EN
      start_q <= wr ? 2'd0 : daddr[3:2];
`else
      start_q <= '0;
`endif
    end else if (accept) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  // A request still high at completion must drop for a cycle before it is served again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b1;
    end else if (state == DONE) begin
      armed_q <= 1'b0;
    end else if (!req) begin
      armed_q <= 1'b1;
    end
  end

  // Stall watchdog: err is raised on the stalled cycle that brings the run to TMO_CYC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (mem_cs && !mem_ready) begin
      if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
      if ((32'(tmo_q) + 32'd1) >= TMO_CYC) err_q <= 1'b1;
    end else if (accept) begin
      tmo_q <= '0;
    end
  end

  // Read data arrives the cycle after an accepted read beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      pend_q    <= accept && !mem_we;
      valid_q   <= pend_q;
      if (pend_q) data_q <= mem_rdata;
      wr_done_q <= (state == DONE) && wr_q;
      rd_done_q <= (state == DONE) && !wr_q;
    end
  end

  assign data_i  = data_q;
  assign valid   = valid_q;
  assign wr_done = wr_done_q;
  assign rd_done = rd_done_q;
  assign err     = err_q;

endmodule
